sha3512_round_ctrl: RTL and testbench
=====================================

Name: sha3512_round_ctrl

Overview:
- Control FSM for the SHA3-512 coprocessor.
- Accepts 576-bit rate blocks from the host over a valid/ready handshake.
- For each block: pulses absorb into the 1600-bit Keccak state, then steps the Keccak-p permutation through NR rounds (one round per clock).
- After the last round of the final block, drives the write strobe of the 576-bit data-out register, then signals completion to the host.

Parameters:
- NR, 24, number of Keccak-p rounds per permutation.
- ROUND_W, 5, width of the round index (must satisfy 2**ROUND_W >= NR).

Ports:
- inClk  input  1  clock; all logic on rising edge.
- inInit  input  1  reset, synchronous, active-high; also clears datapath state via outStateClr.
- inBlockValid  input  1  host presents a padded 576-bit block.
- inBlockLast  input  1  qualifies inBlockValid; block is the final block of the message.
- outBlockReady  output  1  controller can accept a block this cycle.
- outAbsorb  output  1  one-cycle pulse: XOR the presented block into the state register.
- outStateClr  output  1  one-cycle pulse: zero the state register before absorbing.
- outRoundEn  output  1  high while a permutation round is executed this cycle.
- outRoundIdx  output  ROUND_W  current round number, 0..NR-1 (selects the iota constant).
- outDataOutWr  output  1  write strobe to the data-out register (its inWr).
- outDataOutInit  output  1  clear strobe to the data-out register (its inInit).
- outBusy  output  1  message in progress (between first accept and outDone).
- outDone  output  1  one-cycle pulse: digest valid on the data-out register.

Behaviour:
- States: IDLE, ROUND, DONE. State register, round counter and firstBlock flag are all updated on rising inClk.
- inInit=1 (any state, including mid-round):
  - Next state IDLE; round counter 0; firstBlock=1.
  - All outputs 0 except outStateClr=1 and outDataOutInit=1 during the inInit cycle.
  - The cycle after inInit deasserts: outBlockReady=1.
- IDLE:
  - outBlockReady=1, outRoundEn=0.
  - Accept when inBlockValid & outBlockReady:
    - outAbsorb=1 in the accept cycle.
    - If firstBlock=1: outStateClr=1 in the same cycle (datapath clears then XORs, i.e. loads the block) and outDataOutInit=1.
    - lastLatched <= inBlockLast; firstBlock <= 0; outBusy <= 1; counter <= 0; next state ROUND.
- ROUND:
  - outBlockReady=0; inBlockValid is ignored and the host must hold the block.
  - outRoundEn=1; outRoundIdx=counter; counter increments each cycle.
  - In the cycle counter==NR-1:
    - If lastLatched=1: outDataOutWr=1 combinationally in that same cycle (data-out captures the final round's output at that edge); next state DONE.
    - Else: next state IDLE, outBusy stays 1.
- DONE (one cycle):
  - outDone=1; outBusy <= 0; firstBlock <= 1; next state IDLE.
- Latency:
  - Block accepted at cycle T; rounds occupy T+1..T+NR.
  - Digest visible on the data-out register from T+NR+1; outDone at T+NR+1.
  - Single-block message: NR+2 cycles from accept to IDLE.
- Multi-block: the next block can be accepted in the first IDLE cycle after its predecessor's rounds; there are no extra bubbles.
- Counter never wraps in normal operation. If counter reaches NR-1 without leaving ROUND (illegal), it returns to IDLE on the next edge.
- outRoundIdx=0 whenever outRoundEn=0.
- outAbsorb, outStateClr, outDataOutWr, outDataOutInit and outDone are single-cycle pulses, never held.

Decomposition:
- Shared package sha3512_pkg: NR and ROUND_W constants, state encoding (IDLE=2'd0, ROUND=2'd1, DONE=2'd2), RATE_W=576, STATE_W=1600.
- One natural sub-module: sha3512_round_cnt, the round counter with clear, enable and terminal-count output (counter==NR-1).
- The FSM stays in sha3512_round_ctrl.

Test Plan:
- Reset, then single last block at T=10:
  - outAbsorb, outStateClr and outDataOutInit high at 10.
  - outRoundEn 11..34 with outRoundIdx 0..23.
  - outDataOutWr high at 34 only; outDone at 35; outBlockReady high again at 36.
- Two-block message (block0 last=0 at T=5, inBlockValid held for block1 last=1):
  - block1 accepted at 30 with outStateClr=0; outDataOutWr at 54; outDone at 55.
  - exactly 48 outRoundEn cycles total.
- inBlockValid held high during ROUND: no extra outAbsorb; outBlockReady=0 for all 24 round cycles.
- inInit asserted at round index 10:
  - next cycle IDLE, outRoundEn=0, outDataOutWr never pulses.
  - the following message asserts outStateClr at its accept.
- Back-to-back single-block messages: second accept 26 cycles after first; both assert outStateClr and outDataOutInit; outDone pulses twice, each one cycle.

Source files
------------

// File: rtl/sha3512_pkg.sv
// rtl/sha3512_pkg.sv - shared constants and state encoding for the SHA3-512 round controller
//
// Purpose : permutation round count, round index width, datapath widths and
//           the controller state encoding, imported by the controller files.
// Ports   : none (package).

package sha3512_pkg;

    // Keccak-p rounds per permutation and the width of the round index.
    localparam int NR      = 24;
    localparam int ROUND_W = 5;

    // Datapath widths of the coprocessor this controller steers.
    localparam int RATE_W  = 576;
    localparam int STATE_W = 1600;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/sha3512_round_cnt.sv
// rtl/sha3512_round_cnt.sv - Keccak-p round counter with clear, enable and terminal count
//
// Purpose : counts permutation rounds 0..NR-1 and flags the final round.
// Ports   : clk     - clock, rising edge
//           rst     - synchronous active-high reset
//           clr     - synchronous clear to round 0
//           en      - advance one round this cycle
//           cnt     - current round index
//           tc      - high while cnt == NR-1

module sha3512_round_cnt
    import sha3512_pkg::*;
#(
    parameter int CNT_NR  = NR,
    parameter int CNT_W   = ROUND_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CNT_NR - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    assign cnt = cnt_q;
    assign tc  = (cnt_q == LAST_IDX);

    // The counter never wraps past NR-1: the terminal round always
    // returns it to 0, so a permutation that somehow stays enabled
    // restarts cleanly rather than running into unused indices.
    always_comb begin
        cnt_d = cnt_q;
        if (clr || (en && tc)) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sha3512_round_ctrl.sv
// rtl/sha3512_round_ctrl.sv - control FSM for the SHA3-512 coprocessor absorb/permute/squeeze flow
//
// Purpose : accepts rate blocks from the host, pulses absorb into the Keccak
//           state, steps NR permutation rounds one per clock, then writes
//           the data-out register and signals completion.
// Ports   : inClk          - clock, rising edge
//           inInit         - synchronous active-high reset; also clears datapath
//           inBlockValid   - host presents a padded rate block
//           inBlockLast    - the presented block is the final one
//           outBlockReady  - a block can be accepted this cycle
//           outAbsorb      - XOR the presented block into the state
//           outStateClr    - zero the state before absorbing
//           outRoundEn     - a permutation round executes this cycle
//           outRoundIdx    - current round number (iota select)
//           outDataOutWr   - write strobe of the data-out register
//           outDataOutInit - clear strobe of the data-out register
//           outBusy        - message in progress
//           outDone        - digest valid on the data-out register

module sha3512_round_ctrl
    import sha3512_pkg::*;
#(
    parameter int NR_P      = NR,
    parameter int ROUND_W_P = ROUND_W
) (
    input  logic                 inClk,
    input  logic                 inInit,
    input  logic                 inBlockValid,
    input  logic                 inBlockLast,
    output logic                 outBlockReady,
    output logic                 outAbsorb,
    output logic                 outStateClr,
    output logic                 outRoundEn,
    output logic [ROUND_W_P-1:0] outRoundIdx,
    output logic                 outDataOutWr,
    output logic                 outDataOutInit,
    output logic                 outBusy,
    output logic                 outDone
);

    state_e state_d;
    state_e state_q;
    logic   first_d;
    logic   first_q;
    logic   last_d;
    logic   last_q;
    logic   busy_d;
    logic   busy_q;

    logic                 cnt_clr;
    logic                 cnt_en;
    logic [ROUND_W_P-1:0] cnt_val;
    logic                 cnt_tc;

    sha3512_round_cnt #(
        .CNT_NR (NR_P),
        .CNT_W  (ROUND_W_P)
    ) u_round_cnt (
        .clk (inClk),
        .rst (inInit),
        .clr (cnt_clr),
        .en  (cnt_en),
        .cnt (cnt_val),
        .tc  (cnt_tc)
    );

    always_comb begin
        state_d        = state_q;
        first_d        = first_q;
        last_d         = last_q;
        busy_d         = busy_q;
        cnt_clr        = 1'b1;
        cnt_en         = 1'b0;
        outBlockReady  = 1'b0;
        outAbsorb      = 1'b0;
        outStateClr    = 1'b0;
        outRoundEn     = 1'b0;
        outRoundIdx    = '0;
        outDataOutWr   = 1'b0;
        outDataOutInit = 1'b0;
        outBusy        = busy_q;
        outDone        = 1'b0;

        if (inInit) begin
            // Init overrides whatever the FSM was doing, including a
            // permutation in flight; only the two clear strobes are driven.
            state_d        = ST_IDLE;
            first_d        = 1'b1;
            last_d         = 1'b0;
            busy_d         = 1'b0;
            outBusy        = 1'b0;
            outStateClr    = 1'b1;
            outDataOutInit = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    outBlockReady = 1'b1;
                    if (inBlockValid) begin
                        outAbsorb = 1'b1;
                        // First block of a message: clearing and XORing in
                        // the same cycle loads the block into a zero state.
                        if (first_q) begin
                            outStateClr    = 1'b1;
                            outDataOutInit = 1'b1;
                        end
                        last_d  = inBlockLast;
                        first_d = 1'b0;
                        busy_d  = 1'b1;
                        state_d = ST_ROUND;
                    end
                end

                ST_ROUND: begin
                    cnt_clr     = 1'b0;
                    cnt_en      = 1'b1;
                    outRoundEn  = 1'b1;
                    outRoundIdx = cnt_val;
                    if (cnt_tc) begin
                        // The data-out register captures the final round's
                        // output at the same edge that ends the permutation.
                        if (last_q) begin
                            outDataOutWr = 1'b1;
                            state_d      = ST_DONE;
                        end else begin
                            state_d      = ST_IDLE;
                        end
                    end
                end

                ST_DONE: begin
                    outDone = 1'b1;
                    busy_d  = 1'b0;
                    first_d = 1'b1;
                    state_d = ST_IDLE;
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge inClk) begin
        if (inInit) begin
            state_q <= ST_IDLE;
            first_q <= 1'b1;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: tb/tb_sha3512_round_ctrl.sv
// tb/tb_sha3512_round_ctrl.sv - directed self-checking bench for sha3512_round_ctrl

module tb_sha3512_round_ctrl;

    logic       inClk;
    logic       inInit;
    logic       inBlockValid;
    logic       inBlockLast;
    logic       outBlockReady;
    logic       outAbsorb;
    logic       outStateClr;
    logic       outRoundEn;
    logic [4:0] outRoundIdx;
    logic       outDataOutWr;
    logic       outDataOutInit;
    logic       outBusy;
    logic       outDone;

    int total;
    int bad;

    sha3512_round_ctrl dut (
        .inClk          (inClk),
        .inInit         (inInit),
        .inBlockValid   (inBlockValid),
        .inBlockLast    (inBlockLast),
        .outBlockReady  (outBlockReady),
        .outAbsorb      (outAbsorb),
        .outStateClr    (outStateClr),
        .outRoundEn     (outRoundEn),
        .outRoundIdx    (outRoundIdx),
        .outDataOutWr   (outDataOutWr),
        .outDataOutInit (outDataOutInit),
        .outBusy        (outBusy),
        .outDone        (outDone)
    );

    // Output vector order: ready absorb clr init en idx[4:0] wr done busy
    logic [12:0] obs;
    assign obs = {outBlockReady, outAbsorb, outStateClr, outDataOutInit,
                  outRoundEn, outRoundIdx, outDataOutWr, outDone, outBusy};

    function automatic logic [12:0] pack(input logic ready, input logic absorb,
                                         input logic clr, input logic init,
                                         input logic en, input logic [4:0] idx,
                                         input logic wr, input logic done,
                                         input logic busy);
        return {ready, absorb, clr, init, en, idx, wr, done, busy};
    endfunction

    initial begin
        inClk = 1'b0;
        forever #5 inClk = ~inClk;
    end

    task automatic test_reset();
        logic [12:0] exp;
        inInit       = 1'b1;
        inBlockValid = 1'b1;
        inBlockLast  = 1'b1;
        @(posedge inClk);
        @(posedge inClk);
        #2;
        exp = pack(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL reset_cycle got=%b exp=%b", obs, exp);
        end
        inInit       = 1'b0;
        inBlockValid = 1'b0;
        @(posedge inClk);
        #2;
        exp = pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL after_reset got=%b exp=%b", obs, exp);
        end
    endtask

    task automatic test_single_block();
        logic [12:0] exp;
        logic        en;
        for (int c = 0; c <= 40; c++) begin
            inBlockValid = (c == 10);
            inBlockLast  = 1'b1;
            #1;
            en  = (c >= 11 && c <= 34);
            exp = pack(c <= 10 || c >= 36, c == 10, c == 10, c == 10, en,
                       en ? 5'(c - 11) : 5'd0, c == 34, c == 35,
                       c >= 11 && c <= 35);
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL single c=%0d got=%b exp=%b", c, obs, exp);
            end
            @(posedge inClk);
            #1;
        end
    endtask

    task automatic test_two_block();
        logic [12:0] exp;
        logic        en0;
        logic        en1;
        int          en_cnt;
        int          abs_cnt;
        en_cnt  = 0;
        abs_cnt = 0;
        for (int c = 0; c <= 58; c++) begin
            // Valid stays high through block0's rounds while block1 waits.
            inBlockValid = (c >= 5 && c <= 30);
            inBlockLast  = (c > 5);
            #1;
            en0 = (c >= 6 && c <= 29);
            en1 = (c >= 31 && c <= 54);
            exp = pack(c <= 5 || c == 30 || c >= 56, c == 5 || c == 30,
                       c == 5, c == 5, en0 || en1,
                       en0 ? 5'(c - 6) : (en1 ? 5'(c - 31) : 5'd0),
                       c == 54, c == 55, c >= 6 && c <= 55);
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL two_block c=%0d got=%b exp=%b", c, obs, exp);
            end
            en_cnt  += int'(outRoundEn);
            abs_cnt += int'(outAbsorb);
            @(posedge inClk);
            #1;
        end
        total++;
        if (en_cnt !== 48) begin
            bad++;
            $display("FAIL two_block_round_cycles got=%0d exp=48", en_cnt);
        end
        total++;
        if (abs_cnt !== 2) begin
            bad++;
            $display("FAIL two_block_absorbs got=%0d exp=2", abs_cnt);
        end
    endtask

    task automatic test_init_mid_round();
        logic [12:0] exp;
        logic        en0;
        logic        en1;
        for (int c = 0; c <= 43; c++) begin
            inBlockValid = (c == 2 || c == 16);
            inBlockLast  = 1'b1;
            inInit       = (c == 13);
            #1;
            en0 = (c >= 3 && c <= 12);
            en1 = (c >= 17 && c <= 40);
            if (c == 13) begin
                exp = pack(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
            end else begin
                exp = pack(c <= 2 || (c >= 14 && c <= 16) || c >= 42,
                           c == 2 || c == 16, c == 2 || c == 16,
                           c == 2 || c == 16, en0 || en1,
                           en0 ? 5'(c - 3) : (en1 ? 5'(c - 17) : 5'd0),
                           c == 40, c == 41, en0 || (c >= 17 && c <= 41));
            end
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL init_mid c=%0d got=%b exp=%b", c, obs, exp);
            end
            @(posedge inClk);
            #1;
        end
        inInit = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [12:0] exp;
        logic        en0;
        logic        en1;
        int          done_cnt;
        done_cnt = 0;
        for (int c = 0; c <= 53; c++) begin
            inBlockValid = (c < 52);
            inBlockLast  = 1'b1;
            #1;
            en0 = (c >= 1 && c <= 24);
            en1 = (c >= 27 && c <= 50);
            exp = pack(c == 0 || c == 26 || c >= 52, c == 0 || c == 26,
                       c == 0 || c == 26, c == 0 || c == 26, en0 || en1,
                       en0 ? 5'(c - 1) : (en1 ? 5'(c - 27) : 5'd0),
                       c == 24 || c == 50, c == 25 || c == 51,
                       (c >= 1 && c <= 25) || (c >= 27 && c <= 51));
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL back_to_back c=%0d got=%b exp=%b", c, obs, exp);
            end
            done_cnt += int'(outDone);
            @(posedge inClk);
            #1;
        end
        total++;
        if (done_cnt !== 2) begin
            bad++;
            $display("FAIL back_to_back_done_count got=%0d exp=2", done_cnt);
        end
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        inInit       = 1'b1;
        inBlockValid = 1'b0;
        inBlockLast  = 1'b0;
        test_reset();
        test_single_block();
        test_two_block();
        test_init_mid_round();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
